serial_receiver: RTL and testbench

SERIAL_RECEIVER -- requirements
Module: serial_receiver

---
 rtl/serial_receiver_if.sv | 22 ++
 rtl/serial_receiver.sv | 108 ++++++++++
 tb/tb_serial_receiver.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/serial_receiver_if.sv
// Bus between a serial_receiver and its environment: the serial line,
// the consumer handshake and the status flags.
interface serial_receiver_if;
  logic       serial_in;
  logic       ready;
  logic [6:0] data_out;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    output serial_in, ready,
    input  data_out, valid, parity_err, frame_err, overrun, busy
  );

  modport slave (
    input  serial_in, ready,
    output data_out, valid, parity_err, frame_err, overrun, busy
  );
endinterface

// File: rtl/serial_receiver.sv
// One-sample-per-clock receiver for start + 7 data (LSB first) + even parity + stop frames.
// Parity checking is enabled by defining RX_PARITY_CHECK_EN; otherwise the parity bit is skipped.
module serial_receiver (
  input logic             clk,
  input logic             rstn,
  serial_receiver_if.slave rx
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic [1:0] state;
  logic [2:0] bit_cnt;
  logic [6:0] shift_reg;
  logic       stop_ok;
  logic       parity_ok;
  logic       good_frame;
  logic       handshake;

`ifdef RX_PARITY_CHECK_EN
  logic parity_bit;
`endif

  always_comb begin
    stop_ok    = (state == STOP) && rx.serial_in;
`ifdef RX_PARITY_CHECK_EN
    parity_ok  = ((^shift_reg) == parity_bit);
`else
    parity_ok  = 1'b1;
`endif
    good_frame = stop_ok && parity_ok;
    handshake  = rx.valid && rx.ready;
  end

  assign rx.busy = (state != IDLE);

  // Frame sequencing; STOP always returns to IDLE so a low stop bit is never taken as a start bit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shift_reg <= 7'd0;
`ifdef RX_PARITY_CHECK_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!rx.serial_in) begin
            state   <= DATA;
            bit_cnt <= 3'd0;
          end
        end
        DATA: begin
          shift_reg <= {rx.serial_in, shift_reg[6:1]};
          bit_cnt   <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd6)
            state <= PARITY;
        end
        PARITY: begin
`ifdef RX_PARITY_CHECK_EN
          parity_bit <= rx.serial_in;
`endif
          state <= STOP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A completing word may replace the held one only if it is consumed in the same cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx.data_out  <= 7'd0;
      rx.valid     <= 1'b0;
      rx.frame_err <= 1'b0;
      rx.overrun   <= 1'b0;
    end else begin
      rx.frame_err <= (state == STOP) && !rx.serial_in;
      if (handshake) begin
        rx.valid   <= 1'b0;
        rx.overrun <= 1'b0;
      end
      if (good_frame) begin
        if (!rx.valid || rx.ready) begin
          rx.data_out <= shift_reg;
          rx.valid    <= 1'b1;
        end else begin
          rx.overrun <= 1'b1;
        end
      end
    end
  end

`ifdef RX_PARITY_CHECK_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      rx.parity_err <= 1'b0;
    else
      rx.parity_err <= stop_ok && !parity_ok;
  end
`else
  assign rx.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_receiver.sv
// Scoreboard bench for serial_receiver: frames are pushed as expected events, a negedge
// monitor pops them as the DUT reports words (on handshake) and error pulses.
module tb_serial_receiver;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  serial_receiver_if rx_if ();

  serial_receiver dut (
    .clk  (clk),
    .rstn (rstn),
    .rx   (rx_if)
  );

`ifdef RX_PARITY_CHECK_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam int EV_WORD = 0;
  localparam int EV_PERR = 1;
  localparam int EV_FERR = 2;

  typedef struct {
    int         kind;
    logic [6:0] data;
    int         cycle;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle_cnt = 0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic sendBit(input logic b);
    rx_if.serial_in = b;
    @(posedge clk);
    #1;
  endtask

  // Reference outcome of a frame: stop=0 wins, then parity (if enabled), else a word.
  // Words completed with ready low have no fixed delivery cycle (cycle = -1).
  task automatic applyStimulus(input logic [6:0] d, input logic par_flip, input logic stop_bit,
                               input logic drop, input logic stop_ready);
    exp_t e;
    logic par;
    par     = (^d) ^ par_flip;
    e.data  = d;
    e.cycle = cycle_cnt + 10;
    if (!stop_bit)
      e.kind = EV_FERR;
    else if (PARITY_EN && par_flip)
      e.kind = EV_PERR;
    else begin
      e.kind = EV_WORD;
      if (!stop_ready) e.cycle = -1;
    end
    if (!(e.kind == EV_WORD && drop)) exp_q.push_back(e);
    sendBit(1'b0);
    for (int i = 0; i < 7; i++) sendBit(d[i]);
    sendBit(par);
    rx_if.ready = stop_ready;
    sendBit(stop_bit);
    rx_if.serial_in = 1'b1;
  endtask

  task automatic checkOutput(input string name, input logic [6:0] data, input logic valid,
                             input logic perr, input logic ferr, input logic ovr, input logic busy);
    logic [11:0] act, req;
    act = {rx_if.data_out, rx_if.valid, rx_if.parity_err, rx_if.frame_err, rx_if.overrun, rx_if.busy};
    req = {data, valid, perr, ferr, ovr, busy};
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got data=%h valid=%b perr=%b ferr=%b ovr=%b busy=%b, want data=%h valid=%b perr=%b ferr=%b ovr=%b busy=%b",
               name, act[11:5], act[4], act[3], act[2], act[1], act[0],
               req[11:5], req[4], req[3], req[2], req[1], req[0]);
    end
  endtask

  task automatic popCheck(input int kind, input logic [6:0] data, input string name);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL unexpected_%s: got data=%h at cycle %0d, want no event", name, data, cycle_cnt);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == EV_WORD && e.data != data) ||
          (e.cycle >= 0 && e.cycle != cycle_cnt)) begin
        failures++;
        $display("[TB] FAIL scoreboard_%s: got kind=%0d data=%h cycle=%0d, want kind=%0d data=%h cycle=%0d",
                 name, kind, data, cycle_cnt, e.kind, e.data, e.cycle);
      end
    end
  endtask

  // Monitor: outputs are sampled half a cycle after the edge that produced them
  always @(negedge clk) begin
    if (rstn) begin
      if (rx_if.valid && rx_if.ready) popCheck(EV_WORD, rx_if.data_out, "word");
      if (rx_if.parity_err)          popCheck(EV_PERR, 7'd0, "parity_err");
      if (rx_if.frame_err)           popCheck(EV_FERR, 7'd0, "frame_err");
    end
  end

  initial begin
    logic [6:0] d;
    rx_if.serial_in = 1'b1;
    rx_if.ready     = 1'b1;
    rstn            = 1'b0;
    #2;
    checkOutput("reset_state", 7'h00, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    sendBit(1'b1);
    sendBit(1'b1);
    checkOutput("idle_after_reset", 7'h00, 0, 0, 0, 0, 0);

    applyStimulus(7'h55, 1'b0, 1'b1, 1'b0, 1'b1);
    sendBit(1'b1);
    checkOutput("good_55", 7'h55, 0, 0, 0, 0, 0);

    applyStimulus(7'h55, 1'b1, 1'b1, 1'b0, 1'b1);
    sendBit(1'b1);
    checkOutput("bad_parity_55", 7'h55, 0, 0, 0, 0, 0);

    applyStimulus(7'h2A, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("frame_err_2a", 7'h55, 0, 0, 1, 0, 0);
    applyStimulus(7'h01, 1'b0, 1'b1, 1'b0, 1'b1);
    sendBit(1'b1);
    checkOutput("good_01", 7'h01, 0, 0, 0, 0, 0);

    rx_if.ready = 1'b0;
    applyStimulus(7'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(7'h22, 1'b0, 1'b1, 1'b1, 1'b0);
    sendBit(1'b1);
    sendBit(1'b1);
    checkOutput("overrun_set", 7'h11, 1, 0, 0, 1, 0);
    rx_if.ready = 1'b1;
    sendBit(1'b1);
    rx_if.ready = 1'b0;
    checkOutput("overrun_cleared", 7'h11, 0, 0, 0, 0, 0);

    applyStimulus(7'h33, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(7'h44, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("same_cycle_load", 7'h44, 1, 0, 0, 0, 0);
    sendBit(1'b1);
    checkOutput("same_cycle_drained", 7'h44, 0, 0, 0, 0, 0);

    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    checkOutput("mid_frame_busy", 7'h44, 0, 0, 0, 0, 1);
    rstn = 1'b0;
    #1;
    checkOutput("mid_frame_reset", 7'h00, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    sendBit(1'b1);
    sendBit(1'b1);
    checkOutput("after_abort", 7'h00, 0, 0, 0, 0, 0);
    applyStimulus(7'h7F, 1'b0, 1'b1, 1'b0, 1'b1);
    sendBit(1'b1);
    checkOutput("good_7f", 7'h7F, 0, 0, 0, 0, 0);

    applyStimulus(7'h0F, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(7'h70, 1'b0, 1'b1, 1'b0, 1'b1);

    for (int n = 0; n < 60; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) sendBit(1'b1);
      d = 7'($urandom);
      applyStimulus(d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0), 1'b0, 1'b1);
    end

    repeat (4) sendBit(1'b1);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d outstanding events, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
